bsg_priority_serialize: RTL and testbench

BSG_PRIORITY_SERIALIZE -- requirements
Module: bsg_priority_serialize

---
 rtl/bsg_priority_serialize_pkg.sv | 18 +
 rtl/bsg_priority_encode.sv | 26 ++
 rtl/bsg_priority_serialize.sv | 93 +++++++++
 tb/tb_bsg_priority_serialize.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_priority_serialize_pkg.sv
// Shared constants and helpers for bsg_priority_serialize.
package bsg_priority_serialize_pkg;

  localparam int unsigned coalesce_cnt_width_gp = 8;
  localparam logic [coalesce_cnt_width_gp-1:0] coalesce_cnt_max_gp = 8'd255;

  function automatic logic [coalesce_cnt_width_gp-1:0] coalesce_sat_add
    (input logic [coalesce_cnt_width_gp-1:0] cnt,
     input logic [coalesce_cnt_width_gp-1:0] inc);
    logic [coalesce_cnt_width_gp:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    if (sum > {1'b0, coalesce_cnt_max_gp})
      return coalesce_cnt_max_gp;
    else
      return sum[coalesce_cnt_width_gp-1:0];
  endfunction

endpackage

// File: rtl/bsg_priority_encode.sv
// Priority encoder: index of the highest (lo_to_hi_p=0) or lowest (lo_to_hi_p=1) set bit.
module bsg_priority_encode #(
  parameter int width_p    = 16,
  parameter int lo_to_hi_p = 0
) (
  input  logic [width_p-1:0]         i,
  output logic [$clog2(width_p)-1:0] addr_o,
  output logic                       v_o
);

  localparam int unsigned addr_w_lp = $clog2(width_p);

  // Last matching assignment wins, so the scan direction selects the priority.
  always_comb begin
    addr_o = '0;
    v_o    = |i;
    if (lo_to_hi_p != 0) begin
      for (int unsigned k = width_p; k > 0; k--)
        if (i[k-1]) addr_o = addr_w_lp'(k - 1);
    end else begin
      for (int unsigned k = 0; k < width_p; k++)
        if (i[k]) addr_o = addr_w_lp'(k);
    end
  end

endmodule

// File: rtl/bsg_priority_serialize.sv
// Serializes a vector of request pulses into one registered grant at a time.
// Optional coalesce counter: define BSG_PRIORITY_SERIALIZE_COALESCE_CNT_EN.
module bsg_priority_serialize
  import bsg_priority_serialize_pkg::*;
#(
  parameter int width_p    = 16,
  parameter int lo_to_hi_p = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [width_p-1:0]         set_i,
  output logic                       v_o,
  output logic [$clog2(width_p)-1:0] addr_o,
  input  logic                       yumi_i,
  output logic [width_p-1:0]         pending_o
`ifdef BSG_PRIORITY_SERIALIZE_COALESCE_CNT_EN
  ,
  output logic [coalesce_cnt_width_gp-1:0] coalesce_cnt_o
`endif
);

  localparam int unsigned addr_w_lp = $clog2(width_p);

  logic [width_p-1:0]   pending_r;
  logic [width_p-1:0]   load_onehot;
  logic [addr_w_lp-1:0] enc_addr;
  logic [addr_w_lp-1:0] addr_r;
  logic                 enc_v;
  logic                 v_r;
  logic                 load;

  bsg_priority_encode #(
    .width_p   (width_p),
    .lo_to_hi_p(lo_to_hi_p)
  ) encode (
    .i     (pending_r),
    .addr_o(enc_addr),
    .v_o   (enc_v)
  );

  assign load = (~v_r | yumi_i) & enc_v;

  always_comb begin
    load_onehot = '0;
    if (load) load_onehot[enc_addr] = 1'b1;
  end

  // set_i is OR-ed after the clear so a re-request of the granted bit survives.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pending_r <= '0;
      v_r       <= 1'b0;
      addr_r    <= '0;
    end else begin
      pending_r <= (pending_r & ~load_onehot) | set_i;
      if (load) begin
        v_r    <= 1'b1;
        addr_r <= enc_addr;
      end else if (yumi_i) begin
        v_r <= 1'b0;
      end
    end
  end

  assign v_o       = v_r;
  assign addr_o    = addr_r;
  assign pending_o = pending_r;

`ifdef BSG_PRIORITY_SERIALIZE_COALESCE_CNT_EN
  logic [coalesce_cnt_width_gp-1:0] cnt_r;
  logic [coalesce_cnt_width_gp-1:0] pop;
  logic [width_p-1:0]               dup;

  assign dup = set_i & pending_r;

  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < width_p; k++)
      pop = pop + coalesce_cnt_width_gp'(dup[k]);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) cnt_r <= '0;
    else            cnt_r <= coalesce_sat_add(cnt_r, pop);
  end

  assign coalesce_cnt_o = cnt_r;
`endif

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_priority_serialize.sv
// Self-checking bench for bsg_priority_serialize, both priority directions in parallel.
module tb_bsg_priority_serialize;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] set = '0;
  logic        yumi = 1'b0;

  logic        v0, v1;
  logic [3:0]  addr0, addr1;
  logic [15:0] pend0, pend1;
`ifdef BSG_PRIORITY_SERIALIZE_COALESCE_CNT_EN
  logic [7:0]  cnt0, cnt1;
`endif

  int unsigned total  = 0;
  int unsigned passes = 0;

  // Reference state, index 0 = highest-wins, index 1 = lowest-wins.
  logic [15:0] mpend [2];
  logic        mv    [2];
  logic [3:0]  maddr [2];
  int unsigned mcnt  [2];

  always #5 clk = ~clk;

  bsg_priority_serialize #(.width_p(16), .lo_to_hi_p(0)) dut_hi (
    .clk_i(clk), .reset_n_i(reset_n), .set_i(set), .v_o(v0), .addr_o(addr0),
    .yumi_i(yumi), .pending_o(pend0)
`ifdef BSG_PRIORITY_SERIALIZE_COALESCE_CNT_EN
    , .coalesce_cnt_o(cnt0)
`endif
  );

  bsg_priority_serialize #(.width_p(16), .lo_to_hi_p(1)) dut_lo (
    .clk_i(clk), .reset_n_i(reset_n), .set_i(set), .v_o(v1), .addr_o(addr1),
    .yumi_i(yumi), .pending_o(pend1)
`ifdef BSG_PRIORITY_SERIALIZE_COALESCE_CNT_EN
    , .coalesce_cnt_o(cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Winning index: highest set bit via log2, lowest via isolating the LSB.
  function automatic logic [3:0] pick(input logic [15:0] p, input bit lo);
    int unsigned x;
    if (lo) begin
      x = 32'(p & (~p + 16'd1));
      return 4'($clog2(x));
    end else begin
      x = 32'(p) + 1;
      return 4'($clog2(x) - 1);
    end
  endfunction

  task automatic model_edge();
    logic        ld;
    logic [3:0]  a;
    int unsigned c;
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        mpend[d] = '0; mv[d] = 1'b0; maddr[d] = '0; mcnt[d] = 0;
      end else begin
        c = mcnt[d] + $countones(set & mpend[d]);
        mcnt[d] = (c > 255) ? 255 : c;
        ld = (!mv[d] || yumi) && (mpend[d] != 0);
        if (ld) begin
          a = pick(mpend[d], d == 1);
          mpend[d] = (mpend[d] & ~(16'd1 << a)) | set;
          mv[d] = 1'b1;
          maddr[d] = a;
        end else begin
          mpend[d] = mpend[d] | set;
          if (yumi) mv[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("v_hi", 64'(v0), 64'(mv[0]));
    chk("addr_hi", 64'(addr0), 64'(maddr[0]));
    chk("pend_hi", 64'(pend0), 64'(mpend[0]));
    chk("v_lo", 64'(v1), 64'(mv[1]));
    chk("addr_lo", 64'(addr1), 64'(maddr[1]));
    chk("pend_lo", 64'(pend1), 64'(mpend[1]));
`ifdef BSG_PRIORITY_SERIALIZE_COALESCE_CNT_EN
    chk("cnt_hi", 64'(cnt0), 64'(mcnt[0]));
    chk("cnt_lo", 64'(cnt1), 64'(mcnt[1]));
`endif
  endtask

  task automatic step(input logic rn, input logic [15:0] s, input logic y);
    reset_n = rn; set = s; yumi = y;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Normal-operation step; yumi is only offered while a grant is held.
  task automatic go(input logic [15:0] s, input logic yreq);
    step(1'b1, s, yreq & mv[0]);
  endtask

  initial begin
    int exp_hi [4];
    int exp_lo [4];
    logic [15:0] s;
    exp_hi = '{15, 10, 5, 0};
    exp_lo = '{0, 5, 10, 15};
    for (int d = 0; d < 2; d++) begin
      mpend[d] = '0; mv[d] = 1'b0; maddr[d] = '0; mcnt[d] = 0;
    end

    // Reset state
    step(1'b0, 16'hFFFF, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    chk("rst_v", 64'(v0), 64'd0);
    chk("rst_pend", 64'(pend0), 64'd0);
    chk("rst_addr", 64'(addr1), 64'd0);

    // Single request: pending after one edge, grant after the second
    go(16'h0010, 1'b0);
    chk("single_pend", 64'(pend0), 64'h10);
    chk("single_v_early", 64'(v0), 64'd0);
    go(16'h0000, 1'b0);
    chk("single_v", 64'(v0), 64'd1);
    chk("single_addr", 64'(addr0), 64'd4);
    for (int i = 0; i < 3; i++) go(16'h0000, 1'b0);
    chk("single_hold", 64'(addr0), 64'd4);
    go(16'h0000, 1'b1);
    chk("single_done", 64'(v0), 64'd0);

    // Burst with yumi held: one grant per cycle, both priority orders
    go(16'h8421, 1'b0);
    go(16'h0000, 1'b1);
    chk("burst_hi_0", 64'(addr0), 64'(exp_hi[0]));
    chk("burst_lo_0", 64'(addr1), 64'(exp_lo[0]));
    for (int j = 1; j < 4; j++) begin
      go(16'h0000, 1'b1);
      chk("burst_v", 64'(v0), 64'd1);
      chk("burst_hi", 64'(addr0), 64'(exp_hi[j]));
      chk("burst_lo", 64'(addr1), 64'(exp_lo[j]));
    end
    go(16'h0000, 1'b1);
    chk("burst_end_v", 64'(v0), 64'd0);
    chk("burst_end_pend", 64'(pend1), 64'd0);

    // Re-request of the index currently granted
    go(16'h0008, 1'b0);
    go(16'h0000, 1'b0);
    chk("reset_idx_addr", 64'(addr0), 64'd3);
    go(16'h0008, 1'b0);
    chk("reset_idx_pend", 64'(pend0), 64'h8);
    go(16'h0000, 1'b1);
    chk("reset_idx_regrant_v", 64'(v0), 64'd1);
    chk("reset_idx_regrant", 64'(addr0), 64'd3);
    chk("reset_idx_pend0", 64'(pend0), 64'd0);
    go(16'h0000, 1'b1);
    chk("reset_idx_done", 64'(v0), 64'd0);

    // Reset mid-burst with a stray yumi during reset
    go(16'hFFFF, 1'b0);
    go(16'h0000, 1'b0);
    go(16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    chk("midrst_v", 64'(v0), 64'd0);
    chk("midrst_pend", 64'(pend0), 64'd0);
    go(16'h0002, 1'b0);
    chk("midrst_lat_v", 64'(v1), 64'd0);
    go(16'h0000, 1'b0);
    chk("midrst_lat_addr", 64'(addr1), 64'd1);
    go(16'h0000, 1'b1);

`ifdef BSG_PRIORITY_SERIALIZE_COALESCE_CNT_EN
    // Coalesce counting and saturation
    step(1'b0, 16'h0000, 1'b0);
    go(16'h000F, 1'b0);
    go(16'h0007, 1'b0);
    chk("coal_3_hi", 64'(cnt0), 64'd3);
    chk("coal_3_lo", 64'(cnt1), 64'd3);
    for (int i = 0; i < 100; i++) go(16'h0007, 1'b0);
    chk("coal_sat_hi", 64'(cnt0), 64'd255);
    chk("coal_sat_lo", 64'(cnt1), 64'd255);
    step(1'b0, 16'h0000, 1'b0);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0000;
      if ($urandom_range(0, 99) == 0) step(1'b0, s, 1'($urandom));
      else                            go(s, 1'($urandom));
    end

    // Drain: every outstanding request must be granted and consumed
    for (int i = 0; i < 40; i++) go(16'h0000, 1'b1);
    chk("drain_v", 64'(v0), 64'd0);
    chk("drain_pend_hi", 64'(pend0), 64'd0);
    chk("drain_pend_lo", 64'(pend1), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
